// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM controller serving an instruction fetch port and a data load/store port.
// Ports: clk_in, rst_in (async, active-low); if_req_in/if_addr_in -> if_done_out/if_inst_out;
//   mem_req_in/mem_we_in/mem_addr_in/mem_wdata_in/mem_size_in -> mem_done_out/mem_rdata_out;
//   if_stall_req_out/mem_stall_req_out stall requests; ram_addr_out/ram_wr_out/ram_dout_out/ram_din_in
//   byte RAM port (1-cycle read latency); misalign_out misaligned data access flag.
// Optional: define MEMCTRL_ALIGN_CHECK_EN to reject misaligned data accesses without touching RAM.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_inst_out,
  input  logic        mem_req_in,
  input  logic        mem_we_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_wdata_in,
  input  logic [1:0]  mem_size_in,
  output logic        mem_done_out,
  output logic [31:0] mem_rdata_out,
  output logic        if_stall_req_out,
  output logic        mem_stall_req_out,
  output logic [31:0] ram_addr_out,
  output logic        ram_wr_out,
  output logic [7:0]  ram_dout_out,
  input  logic [7:0]  ram_din_in,
  output logic        misalign_out
);
  localparam logic [2:0] IDLE = 3'd0, IF_RD = 3'd1, MEM_RD = 3'd2, MEM_WR = 3'd3, DONE = 3'd4;
  logic [2:0] state, cnt, len, mem_len;
  logic [31:0] base, wdata, acc, acc_nxt;
  logic is_if, mis_q, mis, act;
  logic [1:0] km1;
`ifdef MEMCTRL_ALIGN_CHECK_EN
  assign mis = (mem_size_in == 2'd1 && mem_addr_in[0]) || (mem_size_in[1] && mem_addr_in[1:0] != 2'd0);
`else
  assign mis = 1'b0;
`endif
  assign mem_len = mem_size_in == 2'd0 ? 3'd1 : mem_size_in == 2'd1 ? 3'd2 : 3'd4;
  assign act = state == IF_RD || state == MEM_RD || state == MEM_WR;
  // RAM data arrives one cycle after its address, so the byte landing at count k belongs to address k-1
  assign km1 = cnt[1:0] - 2'd1;
  always_comb begin
    acc_nxt = acc;
    acc_nxt[{km1, 3'b000} +: 8] = ram_din_in;
  end
  assign ram_addr_out = act ? base + {29'd0, cnt} : 32'd0;
  assign ram_wr_out = state == MEM_WR;
  assign ram_dout_out = ram_wr_out ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'd0;
  assign if_done_out = state == DONE && is_if;
  assign mem_done_out = state == DONE && !is_if;
  assign misalign_out = state == DONE && mis_q;
  // gated by reset so every output reads 0 while reset is held
  assign if_stall_req_out = rst_in && if_req_in && !if_done_out;
  assign mem_stall_req_out = rst_in && mem_req_in && !mem_done_out;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      base <= '0;
      wdata <= '0;
      acc <= '0;
      is_if <= 1'b0;
      mis_q <= 1'b0;
      if_inst_out <= '0;
      mem_rdata_out <= '0;
    end else begin
      case (state)
        IDLE:
          if (mem_req_in) begin
            is_if <= 1'b0;
            base <= mem_addr_in;
            wdata <= mem_wdata_in;
            len <= mem_len;
            cnt <= '0;
            acc <= '0;
            mis_q <= mis;
            if (mis) mem_rdata_out <= '0;
            state <= mis ? DONE : mem_we_in ? MEM_WR : MEM_RD;
          end else if (if_req_in) begin
            is_if <= 1'b1;
            base <= if_addr_in;
            len <= 3'd4;
            cnt <= '0;
            acc <= '0;
            mis_q <= 1'b0;
            state <= IF_RD;
          end
        IF_RD, MEM_RD:
          if (state == IF_RD && !if_req_in) state <= IDLE;
          else begin
            cnt <= cnt + 3'd1;
            if (cnt != 3'd0) acc <= acc_nxt;
            if (cnt == len) begin
              state <= DONE;
              if (is_if) if_inst_out <= acc_nxt;
              else mem_rdata_out <= acc_nxt;
            end
          end
        MEM_WR:
          if (cnt == len - 3'd1) state <= DONE;
          else cnt <= cnt + 3'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
